// File: rtl/vga_pattern_pkg.sv
// Shared definitions for the VGA test-pattern source.
//   mode_e      : pattern select (vertical bars, horizontal bars, checker, box)
//   COLOUR_TBL  : 8-entry {R,G,B} colour table, index 0 = white ... 7 = black
//   btn_t       : one bit per front-panel button
//   step_clamp  : move a box coordinate by one step, saturating at 0 / max
package vga_pattern_pkg;

    localparam int COORD_W = 10;

    typedef enum logic [1:0] {
        MODE_VBAR  = 2'd0,
        MODE_HBAR  = 2'd1,
        MODE_CHECK = 2'd2,
        MODE_BOX   = 2'd3
    } mode_e;

    localparam logic [2:0] C_WHITE   = 3'b111;
    localparam logic [2:0] C_YELLOW  = 3'b110;
    localparam logic [2:0] C_CYAN    = 3'b011;
    localparam logic [2:0] C_GREEN   = 3'b010;
    localparam logic [2:0] C_MAGENTA = 3'b101;
    localparam logic [2:0] C_RED     = 3'b100;
    localparam logic [2:0] C_BLUE    = 3'b001;
    localparam logic [2:0] C_BLACK   = 3'b000;

    // First element of the concatenation lands at index 7.
    localparam logic [7:0][2:0] COLOUR_TBL = {
        C_BLACK, C_BLUE, C_RED, C_MAGENTA, C_GREEN, C_CYAN, C_YELLOW, C_WHITE
    };

    typedef struct packed {
        logic up;
        logic down;
        logic left;
        logic right;
        logic mode_next;
    } btn_t;

    localparam int NUM_BTN = $bits(btn_t);

    // dec/inc both set cancel out; movement saturates instead of wrapping.
    function automatic logic [COORD_W-1:0] step_clamp(
        input logic [COORD_W-1:0] pos,
        input logic               dec,
        input logic               inc,
        input int                 step,
        input int                 max_pos
    );
        logic [COORD_W:0]   sum;
        logic [COORD_W-1:0] res;
        sum = {1'b0, pos} + (COORD_W+1)'(step);
        res = pos;
        if (dec && !inc)
            res = (pos < COORD_W'(step)) ? '0 : pos - COORD_W'(step);
        else if (inc && !dec)
            res = (sum > (COORD_W+1)'(max_pos)) ? COORD_W'(max_pos) : sum[COORD_W-1:0];
        return res;
    endfunction

endpackage

// File: rtl/vga_pattern_gen_if.sv
// Pixel bus between the sync/timing generator and the pattern source.
//   active_area, coord_x, coord_y : timing generator -> pattern source
//   rgb (3*CH_W), mode (2)        : pattern source -> downstream
// master = timing side, slave = pattern source.
interface vga_pattern_gen_if #(
    parameter int CH_W = 1
);
    import vga_pattern_pkg::*;

    logic                  active_area;
    logic [COORD_W-1:0]    coord_x;
    logic [COORD_W-1:0]    coord_y;
    logic [3*CH_W-1:0]     rgb;
    logic [1:0]            mode;

    modport master (
        output active_area, coord_x, coord_y,
        input  rgb, mode
    );

    modport slave (
        input  active_area, coord_x, coord_y,
        output rgb, mode
    );

endinterface

// File: rtl/vga_btn_edge.sv
// Button conditioner: 2-flop synchroniser followed by a rising-edge detector.
//   clk, reset : pixel clock, async active-high reset
//   btn        : raw button level, asynchronous to clk
//   rise       : one-cycle pulse on each synchronised 0->1 transition
module vga_btn_edge (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic rise
);

    // [0],[1] are the synchroniser; [2] is the delayed copy for edge detect.
    logic [2:0] sync_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) sync_q <= '0;
        else       sync_q <= {sync_q[1:0], btn};
    end

    assign rise = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/vga_pattern_gen.sv
// VGA test-pattern source: vertical bars, horizontal bars, checkerboard and a
// button-driven box. Mode changes and box moves are latched as pending and
// only take effect at frame start, so a frame is never drawn with mixed state.
//   clk, reset                 : pixel clock, async active-high reset
//   up/down/left/right         : raw box-move buttons
//   mode_next                  : raw button, each press advances the mode
//   pix (slave)                : active_area/coord_x/coord_y in, rgb/mode out
// rgb is registered: it shows the pixel for the coordinates of the previous clk.
module vga_pattern_gen
    import vga_pattern_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int CH_W     = 1,
    parameter int NUM_BARS = 8,
    parameter int CHK_LOG2 = 5,
    parameter int BOX_SIZE = 32,
    parameter int STEP     = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             up,
    input  logic             down,
    input  logic             left,
    input  logic             right,
    input  logic             mode_next,
    vga_pattern_gen_if.slave pix
);

    localparam int CW        = COORD_W;
    localparam int IDX_W     = 4;
    localparam int HBAR_W    = H_ACTIVE / NUM_BARS;
    localparam int VBAR_W    = V_ACTIVE / NUM_BARS;
    localparam int BOX_X_MAX = H_ACTIVE - BOX_SIZE;
    localparam int BOX_Y_MAX = V_ACTIVE - BOX_SIZE;

    localparam logic [CW-1:0]    BOX_X_RST = CW'(BOX_X_MAX / 2);
    localparam logic [CW-1:0]    BOX_Y_RST = CW'(BOX_Y_MAX / 2);
    localparam logic [IDX_W-1:0] LAST_BAR  = IDX_W'(NUM_BARS - 1);
    localparam logic [CW:0]      HBAR_STEP = (CW+1)'(HBAR_W);
    localparam logic [CW:0]      VBAR_STEP = (CW+1)'(VBAR_W);
    localparam logic [CW:0]      BOX_EDGE  = (CW+1)'(BOX_SIZE);
    localparam logic [CW:0]      BOX_LAST  = (CW+1)'(BOX_SIZE - 1);

    logic [CW-1:0] x, y;
    logic          fs;

    assign x  = pix.coord_x;
    assign y  = pix.coord_y;
    assign fs = pix.active_area && (x == '0) && (y == '0);

    // ---------------------------------------------------------------- buttons
    logic [NUM_BTN-1:0] btn_raw_v, btn_rise_v;
    btn_t               rise, pend_q;

    assign btn_raw_v = {up, down, left, right, mode_next};
    assign rise      = btn_t'(btn_rise_v);

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        vga_btn_edge u_btn (
            .clk   (clk),
            .reset (reset),
            .btn   (btn_raw_v[i]),
            .rise  (btn_rise_v[i])
        );
    end

    // ------------------------------------------------- frame-start state regs
    mode_e         mode_q, mode_nxt, mode_eff;
    logic [CW-1:0] bx_q, by_q, bx_nxt, by_nxt, bx_eff, by_eff;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q <= MODE_VBAR;
            bx_q   <= BOX_X_RST;
            by_q   <= BOX_Y_RST;
            pend_q <= '0;
        end else if (fs) begin
            mode_q <= mode_nxt;
            bx_q   <= bx_nxt;
            by_q   <= by_nxt;
            // An edge landing on the frame-start cycle belongs to the next frame.
            pend_q <= rise;
        end else begin
            pend_q <= pend_q | rise;
        end
    end

    always_comb begin
        mode_nxt = pend_q.mode_next ? mode_e'(mode_q + 2'd1) : mode_q;
        by_nxt   = step_clamp(by_q, pend_q.up,   pend_q.down,  STEP, BOX_Y_MAX);
        bx_nxt   = step_clamp(bx_q, pend_q.left, pend_q.right, STEP, BOX_X_MAX);
    end

    // The frame-start pixel itself is drawn with the newly applied state.
    always_comb begin
        mode_eff = fs ? mode_nxt : mode_q;
        bx_eff   = fs ? bx_nxt   : bx_q;
        by_eff   = fs ? by_nxt   : by_q;
    end

    // ------------------------------------------------------------ bar counters
    // Bars are tracked with an index and the coordinate where the next bar
    // starts; the last bar absorbs the division remainder by never advancing.
    logic [IDX_W-1:0] h_idx_q, h_idx, v_idx_q, v_idx, line_idx;
    logic [CW:0]      h_bnd_q, h_bnd, v_bnd_q, v_bnd;

    always_comb begin
        h_idx = h_idx_q;
        h_bnd = h_bnd_q;
        if (x == '0) begin
            h_idx = '0;
            h_bnd = HBAR_STEP;
        end else if ({1'b0, x} >= h_bnd_q && h_idx_q != LAST_BAR) begin
            h_idx = h_idx_q + 1'b1;
            h_bnd = h_bnd_q + HBAR_STEP;
        end
    end

    // Vertical index is only re-evaluated on the first pixel of each line.
    always_comb begin
        v_idx = v_idx_q;
        v_bnd = v_bnd_q;
        if (y == '0) begin
            v_idx = '0;
            v_bnd = VBAR_STEP;
        end else if ({1'b0, y} >= v_bnd_q && v_idx_q != LAST_BAR) begin
            v_idx = v_idx_q + 1'b1;
            v_bnd = v_bnd_q + VBAR_STEP;
        end
    end

    assign line_idx = (x == '0) ? v_idx : v_idx_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_idx_q <= '0;
            h_bnd_q <= HBAR_STEP;
            v_idx_q <= '0;
            v_bnd_q <= VBAR_STEP;
        end else if (pix.active_area) begin
            h_idx_q <= h_idx;
            h_bnd_q <= h_bnd;
            if (x == '0) begin
                v_idx_q <= v_idx;
                v_bnd_q <= v_bnd;
            end
        end
    end

    // ------------------------------------------------------------ pixel colour
    logic [CW:0] xe, ye, bxe, bye;
    logic        in_box, on_ring;
    logic [2:0]  bar_col, colour;

    assign xe  = {1'b0, x};
    assign ye  = {1'b0, y};
    assign bxe = {1'b0, bx_eff};
    assign bye = {1'b0, by_eff};

    always_comb begin
        in_box  = (xe >= bxe) && (xe < bxe + BOX_EDGE) &&
                  (ye >= bye) && (ye < bye + BOX_EDGE);
        on_ring = (xe == bxe) || (xe == bxe + BOX_LAST) ||
                  (ye == bye) || (ye == bye + BOX_LAST);
        bar_col = COLOUR_TBL[h_idx[2:0]];
        case (mode_eff)
            MODE_VBAR:  colour = bar_col;
            MODE_HBAR:  colour = COLOUR_TBL[line_idx[2:0]];
            MODE_CHECK: colour = (x[CHK_LOG2] ^ y[CHK_LOG2]) ? C_BLACK : C_WHITE;
            default:    colour = in_box ? (on_ring ? C_RED : C_WHITE) : bar_col;
        endcase
    end

    function automatic logic [3*CH_W-1:0] expand(input logic [2:0] c);
        return {{CH_W{c[2]}}, {CH_W{c[1]}}, {CH_W{c[0]}}};
    endfunction

    logic [3*CH_W-1:0] rgb_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) rgb_q <= '0;
        else       rgb_q <= pix.active_area ? expand(colour) : '0;
    end

    assign pix.rgb  = rgb_q;
    assign pix.mode = mode_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Bench for vga_pattern_gen: three instances (defaults, NUM_BARS=3, CH_W=4)
// share one stimulus stream and are compared every clock against a model that
// derives each pixel from the coordinates with plain division.
module tb_vga_pattern_gen;

    localparam int BS = 32;
    localparam int CTAB [8] = '{7, 6, 3, 2, 5, 4, 1, 0};

    logic       clk = 1'b0;
    logic       reset;
    logic       up, down, left, right, mode_next;
    logic       act;
    logic [9:0] cx, cy;

    int vectors     = 0;
    int miscompares = 0;

    // model state
    int       m_mode, m_bx, m_by;
    bit [4:0] m_pend;  // {up, down, left, right, mode_next}

    always #5 clk = ~clk;

    vga_pattern_gen_if #(.CH_W(1)) if0 ();
    vga_pattern_gen_if #(.CH_W(1)) if1 ();
    vga_pattern_gen_if #(.CH_W(4)) if2 ();

    assign if0.active_area = act;  assign if0.coord_x = cx;  assign if0.coord_y = cy;
    assign if1.active_area = act;  assign if1.coord_x = cx;  assign if1.coord_y = cy;
    assign if2.active_area = act;  assign if2.coord_x = cx;  assign if2.coord_y = cy;

    vga_pattern_gen u_d0 (
        .clk(clk), .reset(reset), .up(up), .down(down), .left(left),
        .right(right), .mode_next(mode_next), .pix(if0)
    );
    vga_pattern_gen #(.NUM_BARS(3)) u_d1 (
        .clk(clk), .reset(reset), .up(up), .down(down), .left(left),
        .right(right), .mode_next(mode_next), .pix(if1)
    );
    vga_pattern_gen #(.CH_W(4)) u_d2 (
        .clk(clk), .reset(reset), .up(up), .down(down), .left(left),
        .right(right), .mode_next(mode_next), .pix(if2)
    );

    task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s x=%0d y=%0d got=%h exp=%h t=%0t", tag, cx, cy, got, exp, $time);
        end
    endtask

    function automatic logic [11:0] exp_rgb(input int x, input int y, input int nb, input int chw);
        int hi, vi, c;
        logic [11:0] r;
        hi = x / (640 / nb);  if (hi > nb - 1) hi = nb - 1;
        vi = y / (480 / nb);  if (vi > nb - 1) vi = nb - 1;
        case (m_mode)
            0:       c = CTAB[hi % 8];
            1:       c = CTAB[vi % 8];
            2:       c = (((x / 32) + (y / 32)) % 2 == 1) ? CTAB[7] : CTAB[0];
            default: begin
                c = CTAB[hi % 8];
                if (x >= m_bx && x < m_bx + BS && y >= m_by && y < m_by + BS)
                    c = (x == m_bx || x == m_bx + BS - 1 || y == m_by || y == m_by + BS - 1)
                        ? CTAB[5] : CTAB[0];
            end
        endcase
        r = '0;
        for (int ch = 0; ch < 3; ch++)
            if (c[ch]) r = r | 12'(((1 << chw) - 1) << (ch * chw));
        return r;
    endfunction

    task automatic apply_fs();
        if (m_pend[0]) m_mode = (m_mode + 1) % 4;
        if (m_pend[4] && !m_pend[3]) m_by = (m_by < 4) ? 0 : m_by - 4;
        if (m_pend[3] && !m_pend[4]) m_by = (m_by + 4 > 448) ? 448 : m_by + 4;
        if (m_pend[2] && !m_pend[1]) m_bx = (m_bx < 4) ? 0 : m_bx - 4;
        if (m_pend[1] && !m_pend[2]) m_bx = (m_bx + 4 > 608) ? 608 : m_bx + 4;
        m_pend = '0;
    endtask

    task automatic model_reset();
        m_mode = 0; m_bx = 304; m_by = 224; m_pend = '0;
    endtask

    // One pixel clock: drive, advance, compare all instances.
    task automatic pix(input bit a, input int x, input int y);
        act = a; cx = 10'(x); cy = 10'(y);
        if (a && x == 0 && y == 0) apply_fs();
        @(posedge clk); #1;
        chk("rgb_nb8", 12'(if0.rgb), a ? exp_rgb(x, y, 8, 1) : 12'd0);
        chk("rgb_nb3", 12'(if1.rgb), a ? exp_rgb(x, y, 3, 1) : 12'd0);
        chk("rgb_ch4", if2.rgb,      a ? exp_rgb(x, y, 8, 4) : 12'd0);
        chk("mode",    12'(if0.mode), 12'(m_mode));
    endtask

    task automatic blank();
        pix(1'b0, $urandom_range(0, 1023), $urandom_range(0, 1023));
    endtask

    task automatic line(input int y, input int len);
        for (int x = 0; x < len; x++) begin
            pix(1'b1, x, y);
            if ($urandom_range(0, 19) == 0) blank();
        end
        blank();
    endtask

    // b = {up, down, left, right, mode_next}; pressed during blanking.
    task automatic press(input bit [4:0] b);
        {up, down, left, right, mode_next} = b;
        repeat (4) blank();
        {up, down, left, right, mode_next} = '0;
        repeat (4) blank();
        m_pend = m_pend | b;
    endtask

    // boxrows: run down to just past the box and draw its edge rows fully.
    task automatic frame(input int ylast, input bit boxrows, input int nmax);
        int y, len, last;
        y = 0;
        last = ylast;
        while (y <= last) begin
            len = $urandom_range(1, nmax);
            if (nmax > 6 && $urandom_range(0, 7) == 0) len = $urandom_range(7, 200);
            if (boxrows) begin
                if (y == 0) len = 640;
                else if ((y >= m_by - 1 && y <= m_by + 1) || (y >= m_by + BS - 2 && y <= m_by + BS))
                    len = (m_bx + BS + 2 > 640) ? 640 : m_bx + BS + 2;
            end
            line(y, len);
            if (boxrows) last = (m_by + BS > 479) ? 479 : m_by + BS;
            y++;
        end
    endtask

    initial begin
        reset = 1'b1; act = 1'b0; cx = '0; cy = '0;
        {up, down, left, right, mode_next} = '0;
        model_reset();
        @(posedge clk); #1;
        chk("rst_rgb0", 12'(if0.rgb), 12'd0);
        chk("rst_rgb2", if2.rgb, 12'd0);
        chk("rst_mode", 12'(if0.mode), 12'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (2) blank();

        // mode 0: full-width sweep of line 0, then a tall frame
        frame(0, 1'b0, 6);
        line(0, 0);
        frame(0, 1'b1, 3);
        frame(100, 1'b0, 6);

        // mode press mid-frame only takes effect at the next frame start
        for (int y = 0; y < 3; y++) line(y, 5);
        press(5'b00001);
        for (int y = 3; y < 10; y++) line(y, 5);
        frame(479, 1'b0, 6);            // mode 1, all lines

        press(5'b00001);
        frame(100, 1'b0, 6);            // mode 2
        press(5'b00001);
        frame(0, 1'b0, 3);              // mode 3
        frame(0, 1'b1, 3);

        // wrap 3 -> 0 and back to 3
        for (int i = 0; i < 4; i++) begin
            press(5'b00001);
            frame(0, 1'b0, 3);
        end

        // double press within one frame counts once
        press(5'b00100);
        press(5'b00100);
        frame(0, 1'b1, 3);

        // left presses until stuck at 0
        for (int i = 0; i < 100; i++) begin
            press(5'b00100);
            frame(0, (i == 50 || i == 99), 3);
        end

        // up+down together: no vertical move
        press(5'b11000);
        frame(0, 1'b1, 3);
        press(5'b10000);
        frame(0, 1'b1, 3);

        // clamp at bottom and right edges
        for (int i = 0; i < 60; i++) begin
            press(5'b01000);
            frame(0, 1'b0, 3);
        end
        for (int i = 0; i < 160; i++) begin
            press(5'b00010);
            frame(0, (i == 159), 3);
        end

        // random box moves, mode held at 3
        for (int i = 0; i < 30; i++) begin
            press(5'($urandom_range(0, 31)) & 5'b11110);
            frame(0, (i % 10 == 9), 3);
        end

        // asynchronous reset mid-line while in mode 3
        for (int x = 0; x < 50; x++) pix(1'b1, x, 0);
        #1 reset = 1'b1;
        #1;
        model_reset();
        chk("arst_rgb0", 12'(if0.rgb), 12'd0);
        chk("arst_rgb1", 12'(if1.rgb), 12'd0);
        chk("arst_rgb2", if2.rgb, 12'd0);
        chk("arst_mode", 12'(if0.mode), 12'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (2) blank();
        for (int i = 0; i < 3; i++) begin
            press(5'b00001);
            frame(0, 1'b0, 3);
        end
        frame(0, 1'b1, 3);              // box back at (304,224)

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
